spi_receiver: RTL and testbench
===============================

SPI_RECEIVER -- requirements
Module: SPI_Receiver

Interface
REQ-001 SHALL have parameter SPI_DATALENGTH, default 6'd32, frame length in bits; legal range 1..32.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port SCLK  input  1  SPI serial clock from the master, asynchronous to clk.
REQ-005 SHALL have port CS  input  1  chip select from the master, active-low, asynchronous to clk.
REQ-006 SHALL have port MOSI  input  1  serial data from the master, MSB first.
REQ-007 SHALL have port MISO  output  1  serial data to the master, MSB first.
REQ-008 SHALL have port txData  input  32  reply word; low SPI_DATALENGTH bits used.
REQ-009 SHALL have port recvData  output  32  last complete received word, right-aligned, upper bits zero.
REQ-010 SHALL have port recvValid  output  1  one-clk pulse when recvData updates.
REQ-011 SHALL have port busy  output  1  high while a frame is in progress (state != IDLE).
REQ-012 SHALL have port frameError  output  1  one-clk pulse on a short (aborted) frame.

Function
REQ-013 SHALL pass SCLK, CS, MOSI each through a 2-flop synchronizer plus one history flop; edges are detected on the synchronized signals only.
REQ-014 SHALL operate in SPI mode 0: MOSI sampled on SCLK rising edge; MISO changes only after SCLK falling edge.
REQ-015 SHALL require SCLK high and low phases >= 4 clk each and >= 4 clk from CS falling to the first SCLK rising; behaviour outside this is undefined.
REQ-016 SHALL implement states IDLE, SHIFT, DONE.
REQ-017 IDLE: on detected CS falling edge SHALL load txShift <= txData, clear bitCount and rxShift, go to SHIFT.
REQ-018 SHIFT, SCLK rising edge: SHALL do rxShift <= {rxShift[30:0], MOSI_sync} and bitCount <= bitCount + 1.
REQ-019 SHIFT, SCLK rising edge with bitCount == SPI_DATALENGTH-1: SHALL, next clk, set recvData to the full word, pulse recvValid for exactly one clk, go to DONE.
REQ-020 SHIFT, SCLK falling edge with bitCount >= 1: SHALL shift txShift left by one, filling with 0; a falling edge before the first rising edge is ignored.
REQ-021 MISO SHALL equal txShift[SPI_DATALENGTH-1] in SHIFT and DONE, and 0 in IDLE.
REQ-022 DONE: SHALL ignore all further SCLK edges; on CS rising edge go to IDLE with no pulse.
REQ-023 SHIFT, CS rising edge: SHALL pulse frameError for one clk, leave recvData unchanged, go to IDLE.
REQ-024 CS rising edge coinciding with an SCLK edge in the same clk SHALL take priority; the SCLK edge is discarded.
REQ-025 txData changes after a frame has started SHALL NOT affect the frame in progress.
REQ-026 Latency SHALL be: recvValid asserts 4 clk after the final SCLK rising edge at the pin (2 sync + 1 edge detect + 1 register).
REQ-027 bitCount SHALL be 6 bits and SHALL never wrap; a frame longer than SPI_DATALENGTH is truncated by REQ-022.

Reset
REQ-028 While rst is low, SHALL force state IDLE, recvData 0, recvValid 0, frameError 0, busy 0, MISO 0, txShift 0, rxShift 0, bitCount 0.
REQ-029 While rst is low, SHALL force synchronizer and history flops to SCLK 0, CS 1, MOSI 0.
REQ-030 rst asserted mid-frame SHALL abort immediately with no recvValid and no frameError; after release, the next CS falling edge starts a fresh frame.

Verification
REQ-031 Full frame, master sends 32'hA5A5_0F0F, txData 32'h1234_5678 -> recvData 32'hA5A5_0F0F, one recvValid pulse, master captures 32'h1234_5678.
REQ-032 Back-to-back frames 32'hFFFF_FFFF then 32'h0000_0001 with CS high 8 clk between -> two recvValid pulses, recvData values in order, no frameError.
REQ-033 CS raised after 17 bits -> frameError single pulse, recvData keeps prior value, busy low 4 clk later.
REQ-034 SPI_DATALENGTH=8, master sends 8'h3C then 4 extra SCLK pulses -> recvData 32'h0000_003C, extra pulses ignored, MISO stable.
REQ-035 rst pulsed low after bit 10 -> all outputs at reset values, no pulses; next full frame 32'hDEAD_BEEF received correctly.
REQ-036 txData changed mid-frame from 32'h0000_0000 to 32'hFFFF_FFFF -> master captures 32'h0000_0000.

Source files
------------

// File: rtl/spi_receiver.sv
// SPI mode-0 slave receiver: synchronizes SCLK/CS/MOSI into the clk domain, shifts in one
// frame of SPI_DATALENGTH bits and shifts the reply word out on MISO.
module spi_receiver #(
  parameter logic [5:0] SPI_DATALENGTH = 6'd32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SCLK,
  input  logic        CS,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [31:0] txData,
  output logic [31:0] recvData,
  output logic        recvValid,
  output logic        busy,
  output logic        frameError
);

  localparam int Msb = int'(SPI_DATALENGTH) - 1;
  localparam logic [5:0] LastBit = SPI_DATALENGTH - 6'd1;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  // Per input: [0] meta, [1] synchronized, [2] history.
  logic [2:0] sclk_q, cs_q, mosi_q;

  state_e      state_q, state_d;
  logic [31:0] tx_q, tx_d;
  logic [31:0] rx_q, rx_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        last_q, last_d;
  logic        ferr_q, ferr_d;
  logic [31:0] recv_data_q;
  logic        recv_valid_q;

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_bit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_q <= 3'b000;
      cs_q   <= 3'b111;
      mosi_q <= 3'b000;
    end else begin
      sclk_q <= {sclk_q[1:0], SCLK};
      cs_q   <= {cs_q[1:0], CS};
      mosi_q <= {mosi_q[1:0], MOSI};
    end
  end

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  // MOSI as it stood alongside the last SCLK-low sample, i.e. at the rising edge itself.
  assign mosi_bit  = mosi_q[2];

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    cnt_d   = cnt_q;
    last_d  = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cs_fall) begin
          tx_d    = txData;
          rx_d    = '0;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        // CS rising wins over any SCLK edge seen in the same cycle.
        if (cs_rise) begin
          ferr_d  = 1'b1;
          state_d = StIdle;
        end else if (sclk_rise) begin
          rx_d  = {rx_q[30:0], mosi_bit};
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == LastBit) begin
            last_d  = 1'b1;
            state_d = StDone;
          end
        end else if (sclk_fall && cnt_q != 6'd0) begin
          tx_d = {tx_q[30:0], 1'b0};
        end
      end
      StDone: begin
        if (cs_rise) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      tx_q         <= '0;
      rx_q         <= '0;
      cnt_q        <= '0;
      last_q       <= 1'b0;
      ferr_q       <= 1'b0;
      recv_data_q  <= '0;
      recv_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      ferr_q       <= ferr_d;
      recv_valid_q <= last_q;
      if (last_q) recv_data_q <= rx_q;
    end
  end

  assign MISO       = (state_q == StIdle) ? 1'b0 : tx_q[Msb];
  assign recvData   = recv_data_q;
  assign recvValid  = recv_valid_q;
  assign busy       = (state_q != StIdle);
  assign frameError = ferr_q;

endmodule

// File: tb/tb_spi_receiver.sv
// Bench for spi_receiver: table of SPI frames against a 32-bit instance, plus hand sequences
// for an 8-bit instance, mid-frame reset and latency.
`timescale 1ns/1ps
module tb_spi_receiver;

  localparam int Half = 6;

  logic        clk = 1'b0;
  logic        rst, sclk, mosi, cs32, cs8;
  logic [31:0] tx_data;
  logic        miso32, miso8, valid32, valid8, busy32, busy8, ferr32, ferr8;
  logic [31:0] recv32, recv8;

  always #5 clk = ~clk;

  spi_receiver dut32 (
    .clk(clk), .rst(rst), .SCLK(sclk), .CS(cs32), .MOSI(mosi), .MISO(miso32),
    .txData(tx_data), .recvData(recv32), .recvValid(valid32), .busy(busy32),
    .frameError(ferr32)
  );

  spi_receiver #(.SPI_DATALENGTH(6'd8)) dut8 (
    .clk(clk), .rst(rst), .SCLK(sclk), .CS(cs8), .MOSI(mosi), .MISO(miso8),
    .txData(tx_data), .recvData(recv8), .recvValid(valid8), .busy(busy8),
    .frameError(ferr8)
  );

  int n_checks = 0;
  int n_errors = 0;
  int valid32_cnt = 0, ferr32_cnt = 0, valid8_cnt = 0, ferr8_cnt = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] mosi_word;
    int          nbits;
    logic [31:0] tx_word;
    logic [31:0] tx_mid;
    logic [31:0] exp_recv;
    logic [31:0] exp_miso;
    int          exp_valid;
    int          exp_ferr;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Scoreboard: every recvValid pops the oldest expected word.
  always @(negedge clk) begin
    if (valid32) begin
      valid32_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected: recvValid with recvData %h, no frame outstanding", recv32);
      end else begin
        check("sb_recvData", recv32, exp_q.pop_front());
      end
    end
    if (ferr32) ferr32_cnt++;
    if (valid8) valid8_cnt++;
    if (ferr8) ferr8_cnt++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input bit sel8, output logic m);
    mosi = b;
    wait_clk(Half);
    sclk = 1'b1;
    m = sel8 ? miso8 : miso32;
    wait_clk(Half);
    sclk = 1'b0;
  endtask

  // Drives CS low and nbits of word MSB first; leaves CS low. lat = negedges from the final
  // SCLK rise until recvValid, or -1.
  task automatic frame(input logic [31:0] word, input int nbits, input logic [31:0] tx_mid,
                       input bit sel8, output logic [31:0] cap, output int lat);
    logic m;
    cap = '0;
    lat = -1;
    if (sel8) cs8 = 1'b0;
    else cs32 = 1'b0;
    wait_clk(Half);
    for (int i = 0; i < nbits; i++) begin
      if (i == nbits / 2) tx_data = tx_mid;
      mosi = word[nbits-1-i];
      wait_clk(Half);
      sclk = 1'b1;
      m = sel8 ? miso8 : miso32;
      cap = {cap[30:0], m};
      if (i == nbits - 1) begin
        for (int k = 1; k <= Half; k++) begin
          @(negedge clk);
          if (lat < 0 && (sel8 ? valid8 : valid32)) lat = k;
        end
      end else begin
        wait_clk(Half);
      end
      sclk = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] cap;
    logic [31:0] word;
    logic        m;
    int          lat, v0, f0;

    vecs[0] = '{32'hA5A5_0F0F, 32, 32'h1234_5678, 32'h1234_5678, 32'hA5A5_0F0F, 32'h1234_5678, 1, 0};
    vecs[1] = '{32'hFFFF_FFFF, 32, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 1, 0};
    vecs[2] = '{32'h0000_0001, 32, 32'h8000_0001, 32'h8000_0001, 32'h0000_0001, 32'h8000_0001, 1, 0};
    vecs[3] = '{32'h0001_5555, 17, 32'hCAFE_BABE, 32'hCAFE_BABE, 32'h0000_0001, 32'h0001_95FD, 0, 1};
    vecs[4] = '{32'h5A5A_C3C3, 32, 32'h0000_0000, 32'hFFFF_FFFF, 32'h5A5A_C3C3, 32'h0000_0000, 1, 0};
    vecs[5] = '{32'h8000_0000, 32, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 1, 0};

    rst = 1'b0; sclk = 1'b0; mosi = 1'b0; cs32 = 1'b1; cs8 = 1'b1; tx_data = '0;
    wait_clk(3);
    check("rst_recvData", recv32, 32'h0);
    check("rst_recvValid", 32'(valid32), 32'h0);
    check("rst_busy", 32'(busy32), 32'h0);
    check("rst_MISO", 32'(miso32), 32'h0);
    check("rst_frameError", 32'(ferr32), 32'h0);
    check("rst_recvData8", recv8, 32'h0);
    rst = 1'b1;
    wait_clk(4);

    for (int v = 0; v < 6; v++) begin
      v0 = valid32_cnt;
      f0 = ferr32_cnt;
      tx_data = vecs[v].tx_word;
      if (vecs[v].nbits == 32) exp_q.push_back(vecs[v].mosi_word);
      frame(vecs[v].mosi_word, vecs[v].nbits, vecs[v].tx_mid, 1'b0, cap, lat);
      wait_clk(Half);
      check($sformatf("v%0d_busy_in_frame", v), 32'(busy32), 32'h1);
      cs32 = 1'b1;
      wait_clk(4);
      check($sformatf("v%0d_busy_after_cs", v), 32'(busy32), 32'h0);
      wait_clk(4);
      check($sformatf("v%0d_miso_capture", v), cap, vecs[v].exp_miso);
      check($sformatf("v%0d_recvData", v), recv32, vecs[v].exp_recv);
      check($sformatf("v%0d_valid_pulses", v), 32'(valid32_cnt - v0), 32'(vecs[v].exp_valid));
      check($sformatf("v%0d_ferr_cycles", v), 32'(ferr32_cnt - f0), 32'(vecs[v].exp_ferr));
      if (vecs[v].nbits == 32) check($sformatf("v%0d_latency", v), 32'(lat), 32'd4);
    end

    // 8-bit instance: frame then extra SCLK pulses, which must be ignored.
    tx_data = 32'h0000_00A5;
    frame(32'h0000_003C, 8, 32'h0000_00A5, 1'b1, cap, lat);
    check("d8_latency", 32'(lat), 32'd4);
    check("d8_miso_capture", cap, 32'h0000_00A5);
    for (int i = 0; i < 4; i++) begin
      send_bit(1'b1, 1'b1, m);
      check($sformatf("d8_miso_extra%0d", i), 32'(m), 32'h1);
    end
    cs8 = 1'b1;
    wait_clk(8);
    check("d8_recvData", recv8, 32'h0000_003C);
    check("d8_valid_pulses", 32'(valid8_cnt), 32'd1);
    check("d8_ferr_cycles", 32'(ferr8_cnt), 32'd0);
    check("d8_busy_after", 32'(busy8), 32'h0);

    // Reset in the middle of a frame after 10 bits.
    v0 = valid32_cnt;
    f0 = ferr32_cnt;
    tx_data = 32'hFFFF_FFFF;
    word = 32'h0F0F_F0F0;
    cs32 = 1'b0;
    wait_clk(Half);
    for (int i = 0; i < 10; i++) send_bit(word[31-i], 1'b0, m);
    rst = 1'b0;
    wait_clk(1);
    check("mrst_recvData", recv32, 32'h0);
    check("mrst_busy", 32'(busy32), 32'h0);
    check("mrst_MISO", 32'(miso32), 32'h0);
    check("mrst_recvValid", 32'(valid32), 32'h0);
    check("mrst_frameError", 32'(ferr32), 32'h0);
    cs32 = 1'b1;
    wait_clk(3);
    rst = 1'b1;
    wait_clk(8);
    check("mrst_valid_pulses", 32'(valid32_cnt - v0), 32'd0);
    check("mrst_ferr_cycles", 32'(ferr32_cnt - f0), 32'd0);
    tx_data = 32'h1357_9BDF;
    exp_q.push_back(32'hDEAD_BEEF);
    frame(32'hDEAD_BEEF, 32, 32'h1357_9BDF, 1'b0, cap, lat);
    wait_clk(Half);
    cs32 = 1'b1;
    wait_clk(8);
    check("post_rst_recvData", recv32, 32'hDEAD_BEEF);
    check("post_rst_miso_capture", cap, 32'h1357_9BDF);
    check("post_rst_valid_pulses", 32'(valid32_cnt - v0), 32'd1);
    check("post_rst_ferr_cycles", 32'(ferr32_cnt - f0), 32'd0);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
